uart_tx_arbiter: RTL and testbench

- Shares the single UART transmitter between NUM_REQ byte sources, e.g. the GPIO echo path and a status/report generator.
- Round-robin arbitration runs at message granularity: a granted requester keeps the transmitter until it sends a byte flagged last.
- A lock timeout prevents a stalled owner from starving the other requesters.
- Sits between the requesters and the UART transmit-data interface, in place of a direct source-to-UART connection.

---
 rtl/uart_tx_arbiter.sv | 194 +++++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
// Shares one UART transmitter between NUM_REQ byte sources. Arbitration is
// round-robin per message: once a requester is granted it owns the
// transmitter until it hands over a byte flagged last. If the owner goes
// quiet mid-message for LOCK_TIMEOUT cycles, the lock is dropped so that the
// other requesters are not starved.
//
// Ports:
//   clk, rst    system clock, synchronous active-high reset
//   req_valid   per-requester byte available
//   req_data    per-requester byte, requester i at [i*DATA_W +: DATA_W]
//   req_last    per-requester end-of-message flag
//   req_ready   one-hot accept strobe (valid & ready = byte taken)
//   tx_data     held byte presented to the UART
//   tx_valid    tx_data holds a byte that has not been sent yet
//   tx_req      UART pulse: tx_data has been consumed
//   grant_id    current (or most recent) owner index
//   busy        a message is in flight (SEND or NEXT)
//   lock_abort  one-cycle pulse when an idle owner loses its lock
module uart_tx_arbiter #(
   parameter int NUM_REQ      = 2,
   parameter int DATA_W       = 8,
   parameter int LOCK_TIMEOUT = 255
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NUM_REQ-1:0]        req_valid,
   input  logic [NUM_REQ*DATA_W-1:0] req_data,
   input  logic [NUM_REQ-1:0]        req_last,
   output logic [NUM_REQ-1:0]        req_ready,
   output logic [DATA_W-1:0]         tx_data,
   output logic                      tx_valid,
   input  logic                      tx_req,
   output logic [1:0]                grant_id,
   output logic                      busy,
   output logic                      lock_abort
);

   localparam logic [1:0]  LAST_IDX    = 2'(NUM_REQ - 1);
   localparam logic [2:0]  NUM_REQ_W   = 3'(NUM_REQ);
   localparam logic [15:0] TIMEOUT_END = 16'(LOCK_TIMEOUT - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEND = 2'd1,
      NEXT = 2'd2
   } state_t;

   state_t              state_reg;
   logic [1:0]          rr_ptr_reg;
   logic [1:0]          grant_id_reg;
   logic                locked_reg;
   logic [DATA_W-1:0]   hold_reg;
   logic                tx_valid_reg;
   logic                lock_abort_reg;
   logic [15:0]         timeout_cnt_reg;

   // Requester views widened to the 2-bit index space so that every index
   // expression below is exactly 2 bits wide regardless of NUM_REQ.
   logic [3:0]          valid_ext;
   logic [3:0]          last_ext;
   logic [DATA_W-1:0]   data_arr [4];

   for (genvar gi = 0; gi < 4; gi++) begin : g_ext
      if (gi < NUM_REQ) begin : g_used
         assign valid_ext[gi] = req_valid[gi];
         assign last_ext[gi]  = req_last[gi];
         assign data_arr[gi]  = req_data[gi*DATA_W +: DATA_W];
      end else begin : g_unused
         assign valid_ext[gi] = 1'b0;
         assign last_ext[gi]  = 1'b0;
         assign data_arr[gi]  = '0;
      end
   end

   // Round-robin search: first valid requester at or after rr_ptr, wrapping.
   logic       win_found;
   logic [1:0] win_idx;
   logic [2:0] cand_sum;

   always_comb begin
      win_found = 1'b0;
      win_idx   = 2'd0;
      cand_sum  = 3'd0;
      for (int k = 0; k < NUM_REQ; k++) begin
         cand_sum = {1'b0, rr_ptr_reg} + 3'(k);
         if (cand_sum >= NUM_REQ_W) begin
            cand_sum = cand_sum - NUM_REQ_W;
         end
         if (!win_found && valid_ext[cand_sum[1:0]]) begin
            win_found = 1'b1;
            win_idx   = cand_sum[1:0];
         end
      end
   end

   // Selected requester for this cycle. In NEXT only the lock owner may be
   // accepted; in SEND nobody is. sel_valid doubles as the accept strobe
   // because ready is only raised towards a valid requester.
   logic       sel_valid;
   logic [1:0] sel_idx;

   always_comb begin
      sel_valid = 1'b0;
      sel_idx   = grant_id_reg;
      if (!rst) begin
         case (state_reg)
            IDLE: begin
               sel_valid = win_found;
               sel_idx   = win_idx;
            end
            NEXT: begin
               sel_valid = valid_ext[grant_id_reg];
               sel_idx   = grant_id_reg;
            end
            default: begin
               sel_valid = 1'b0;
            end
         endcase
      end
   end

   for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_ready
      assign req_ready[gi] = sel_valid && (sel_idx == 2'(gi));
   end

   logic [1:0] next_ptr;
   assign next_ptr = (grant_id_reg == LAST_IDX) ? 2'd0 : grant_id_reg + 2'd1;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg       <= IDLE;
         rr_ptr_reg      <= 2'd0;
         grant_id_reg    <= 2'd0;
         locked_reg      <= 1'b0;
         hold_reg        <= '0;
         tx_valid_reg    <= 1'b0;
         lock_abort_reg  <= 1'b0;
         timeout_cnt_reg <= 16'd0;
      end else begin
         lock_abort_reg <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (sel_valid) begin
                  hold_reg     <= data_arr[sel_idx];
                  grant_id_reg <= sel_idx;
                  locked_reg   <= !last_ext[sel_idx];
                  tx_valid_reg <= 1'b1;
                  state_reg    <= SEND;
               end
            end
            SEND: begin
               if (tx_req) begin
                  tx_valid_reg <= 1'b0;
                  if (locked_reg) begin
                     timeout_cnt_reg <= 16'd0;
                     state_reg       <= NEXT;
                  end else begin
                     // Pointer moves only at message end, never per byte.
                     rr_ptr_reg <= next_ptr;
                     state_reg  <= IDLE;
                  end
               end
            end
            NEXT: begin
               // An accept in the timeout cycle takes priority over the abort.
               if (sel_valid) begin
                  hold_reg     <= data_arr[sel_idx];
                  locked_reg   <= !last_ext[sel_idx];
                  tx_valid_reg <= 1'b1;
                  state_reg    <= SEND;
               end else if (timeout_cnt_reg == TIMEOUT_END) begin
                  lock_abort_reg <= 1'b1;
                  locked_reg     <= 1'b0;
                  rr_ptr_reg     <= next_ptr;
                  state_reg      <= IDLE;
               end else begin
                  timeout_cnt_reg <= timeout_cnt_reg + 16'd1;
               end
            end
            default: begin
               state_reg <= IDLE;
            end
         endcase
      end
   end

   assign tx_data    = hold_reg;
   assign tx_valid   = tx_valid_reg;
   assign grant_id   = grant_id_reg;
   assign busy       = (state_reg == SEND) || (state_reg == NEXT);
   assign lock_abort = lock_abort_reg;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Testbench for uart_tx_arbiter (NUM_REQ=2, DATA_W=8, LOCK_TIMEOUT=4).
// Directed steps follow the block's test plan; a randomized phase then feeds
// message queues into both requesters and compares the UART byte stream with
// the order predicted by strict per-message round-robin.
module tb_uart_tx_arbiter;

   logic        clk;
   logic        rst;
   logic [1:0]  req_valid;
   logic [15:0] req_data;
   logic [1:0]  req_last;
   logic [1:0]  req_ready;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_req;
   logic [1:0]  grant_id;
   logic        busy;
   logic        lock_abort;

   int checks;
   int failures;

   uart_tx_arbiter #(
      .NUM_REQ      (2),
      .DATA_W       (8),
      .LOCK_TIMEOUT (4)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_data   (req_data),
      .req_last   (req_last),
      .req_ready  (req_ready),
      .tx_data    (tx_data),
      .tx_valid   (tx_valid),
      .tx_req     (tx_req),
      .grant_id   (grant_id),
      .busy       (busy),
      .lock_abort (lock_abort)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expd);
      checks++;
      assert (obs === expd)
      else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expd);
      end
   endtask

   // Advance past the next rising edge; outputs are then sampled 1 time unit
   // after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Randomized-phase state: per-requester byte lists and the expected stream.
   logic [7:0] rd [2][24];
   bit         rl [2][24];
   int         rn [2];
   int         pos [2];
   int         stall [2];
   bit         mid [2];
   bit         rv [2];
   int         p [2];
   int         turn;
   int         r;
   int         len;
   bit         done;
   logic [7:0] exp_q [$];
   logic [1:0] acc;
   logic [1:0] blocked;

   initial begin
      checks    = 0;
      failures  = 0;
      rst       = 1'b1;
      req_valid = 2'b11;
      req_data  = 16'h2211;
      req_last  = 2'b11;
      tx_req    = 1'b0;

      // Reset held for two cycles with both requesters valid.
      for (int c = 0; c < 2; c++) begin
         tick();
         check("rst_ready", req_ready, 2'b00);
         check("rst_tx_valid", tx_valid, 1'b0);
         check("rst_tx_data", tx_data, 8'h00);
         check("rst_grant", grant_id, 2'd0);
         check("rst_busy", busy, 1'b0);
         check("rst_abort", lock_abort, 1'b0);
      end
      rst = 1'b0;
      #1;
      check("first_ready", req_ready, 2'b01);
      tick();
      req_valid = 2'b00;
      check("first_tx_valid", tx_valid, 1'b1);
      check("first_tx_data", tx_data, 8'h11);
      check("first_grant", grant_id, 2'd0);
      check("first_busy", busy, 1'b1);
      tx_req = 1'b1;
      tick();
      tx_req = 1'b0;
      check("first_done_valid", tx_valid, 1'b0);
      check("first_done_busy", busy, 1'b0);

      // Single byte, UART consumes it 10 cycles after acceptance.
      req_data[7:0] = 8'h41;
      req_last      = 2'b01;
      req_valid     = 2'b01;
      #1;
      check("single_ready", req_ready, 2'b01);
      tick();
      req_valid = 2'b00;
      check("single_tx_valid", tx_valid, 1'b1);
      check("single_tx_data", tx_data, 8'h41);
      for (int c = 0; c < 9; c++) begin
         tick();
         check("single_hold", {tx_valid, tx_data}, {1'b1, 8'h41});
      end
      tx_req = 1'b1;
      tick();
      tx_req = 1'b0;
      check("single_drop", tx_valid, 1'b0);
      check("single_idle", busy, 1'b0);
      check("single_grant_hold", grant_id, 2'd0);

      // Message lock: req0 sends 0x48,0x49 while req1 waits with 0x55.
      req_data[7:0] = 8'h48;
      req_last      = 2'b00;
      req_valid     = 2'b01;
      #1;
      check("lock_ready0", req_ready, 2'b01);
      tick();
      req_data  = 16'h5549;
      req_last  = 2'b11;
      req_valid = 2'b11;
      #1;
      check("lock_send_ready", req_ready, 2'b00);
      check("lock_byte0", tx_data, 8'h48);
      tx_req = 1'b1;
      tick();
      tx_req = 1'b0;
      #1;
      check("lock_next_ready", req_ready, 2'b01);
      check("lock_next_valid", tx_valid, 1'b0);
      tick();
      req_valid = 2'b10;
      check("lock_byte1", tx_data, 8'h49);
      check("lock_byte1_grant", grant_id, 2'd0);
      #1;
      check("lock_req1_blocked", req_ready, 2'b00);
      tx_req = 1'b1;
      tick();
      tx_req = 1'b0;
      #1;
      check("lock_req1_ready", req_ready, 2'b10);
      tick();
      req_valid = 2'b00;
      check("lock_byte2", tx_data, 8'h55);
      check("lock_byte2_grant", grant_id, 2'd1);
      tx_req = 1'b1;
      tick();
      tx_req = 1'b0;

      // Round-robin with single-byte messages on both requesters.
      req_data  = 16'hB0A0;
      req_last  = 2'b11;
      req_valid = 2'b11;
      for (int m = 0; m < 6; m++) begin
         tick();
         check("rr_grant", grant_id, 2'(m % 2));
         check("rr_data", tx_data, (m % 2 == 0) ? 8'hA0 : 8'hB0);
         tx_req = 1'b1;
         tick();
         tx_req = 1'b0;
      end
      req_valid = 2'b00;

      // Lock timeout: req1 opens a message and goes silent, req0 waits.
      req_data[15:8] = 8'h31;
      req_last       = 2'b00;
      req_valid      = 2'b10;
      tick();
      req_data[7:0] = 8'h22;
      req_last      = 2'b01;
      req_valid     = 2'b01;
      check("to_byte", tx_data, 8'h31);
      check("to_grant", grant_id, 2'd1);
      tx_req = 1'b1;
      tick();
      tx_req = 1'b0;
      #1;
      check("to_blocked", req_ready, 2'b00);
      check("to_busy", busy, 1'b1);
      for (int c = 0; c < 3; c++) begin
         tick();
         check("to_no_abort", lock_abort, 1'b0);
      end
      tick();
      check("to_abort", lock_abort, 1'b1);
      check("to_abort_busy", busy, 1'b0);
      #1;
      check("to_req0_ready", req_ready, 2'b01);
      tick();
      req_valid = 2'b00;
      check("to_abort_pulse", lock_abort, 1'b0);
      check("to_req0_byte", tx_data, 8'h22);
      check("to_req0_grant", grant_id, 2'd0);
      tx_req = 1'b1;
      tick();
      tx_req = 1'b0;

      // Reset in the middle of a message.
      req_data[7:0] = 8'h77;
      req_last      = 2'b00;
      req_valid     = 2'b01;
      tick();
      check("mid_tx_valid", tx_valid, 1'b1);
      rst = 1'b1;
      tick();
      check("mid_rst_valid", tx_valid, 1'b0);
      check("mid_rst_data", tx_data, 8'h00);
      check("mid_rst_grant", grant_id, 2'd0);
      check("mid_rst_busy", busy, 1'b0);
      check("mid_rst_ready", req_ready, 2'b00);
      rst       = 1'b0;
      req_valid = 2'b00;
      tx_req    = 1'b1;
      tick();
      tx_req = 1'b0;
      check("mid_ignore_req", {busy, tx_valid}, 2'b00);
      req_data  = 16'h3412;
      req_last  = 2'b11;
      req_valid = 2'b11;
      #1;
      check("mid_restart_ready", req_ready, 2'b01);
      tick();
      req_valid = 2'b00;
      check("mid_restart_data", tx_data, 8'h12);
      check("mid_restart_grant", grant_id, 2'd0);
      tx_req = 1'b1;
      tick();
      tx_req = 1'b0;

      // Randomized messages: 6 per requester, 1..3 bytes each.
      for (int i = 0; i < 2; i++) begin
         rn[i] = 0;
         for (int m = 0; m < 6; m++) begin
            len = int'($urandom_range(1, 3));
            for (int b = 0; b < len; b++) begin
               rd[i][rn[i]] = 8'($urandom);
               rl[i][rn[i]] = (b == len - 1);
               rn[i]++;
            end
         end
         pos[i]   = 0;
         stall[i] = 0;
         mid[i]   = 1'b0;
         rv[i]    = 1'b1;
         p[i]     = 0;
      end

      // Both requesters always have a message ready between messages, so the
      // stream is whole messages in strict alternation starting with req 0.
      turn = 0;
      while (p[0] < rn[0] || p[1] < rn[1]) begin
         r    = (p[turn] < rn[turn]) ? turn : 1 - turn;
         done = 1'b0;
         while (!done) begin
            exp_q.push_back(rd[r][p[r]]);
            done = rl[r][p[r]];
            p[r]++;
         end
         turn = 1 - r;
      end

      rst = 1'b1;
      req_valid = 2'b00;
      tick();
      rst       = 1'b0;
      req_valid = {rv[1], rv[0]};
      req_data  = {rd[1][0], rd[0][0]};
      req_last  = {rl[1][0], rl[0][0]};

      for (int cyc = 0; cyc < 4000 && exp_q.size() > 0; cyc++) begin
         @(negedge clk);
         blocked = {mid[0], mid[1]};
         check("rand_onehot", ($countones(req_ready) <= 1), 1'b1);
         check("rand_lock_block", req_ready & blocked, 2'b00);
         check("rand_no_abort", lock_abort, 1'b0);
         acc = req_valid & req_ready;
         if (tx_valid && $urandom_range(0, 2) == 0) begin
            check("rand_stream", tx_data, exp_q[0]);
            void'(exp_q.pop_front());
            tx_req = 1'b1;
         end
         tick();
         tx_req = 1'b0;
         for (int i = 0; i < 2; i++) begin
            if (acc[i]) begin
               mid[i] = !rl[i][pos[i]];
               pos[i]++;
               if (pos[i] >= rn[i]) begin
                  rv[i] = 1'b0;
               end else if (mid[i]) begin
                  // Short mid-message pause, well inside the lock timeout.
                  stall[i] = int'($urandom_range(0, 2));
                  rv[i]    = (stall[i] == 0);
               end else begin
                  rv[i] = 1'b1;
               end
            end else if (stall[i] > 0) begin
               stall[i]--;
               if (stall[i] == 0) rv[i] = 1'b1;
            end
         end
         req_valid = {rv[1], rv[0]};
         req_data  = {rd[1][pos[1]], rd[0][pos[0]]};
         req_last  = {rl[1][pos[1]], rl[0][pos[0]]};
      end
      check("rand_drained", exp_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
